// File: rtl/shifter_sll_seq_pkg.sv
// Shared ALU definitions: function codes, shifter FSM states and default widths.
package shifter_sll_seq_pkg;

  // Defaults shared by the left and right shifters.
  localparam int unsigned AluWidth  = 32;
  localparam int unsigned AluShamtW = 5;

  // ALU function codes.
  localparam logic [5:0] FnSll = 6'b000000;
  localparam logic [5:0] FnSrl = 6'b000010;

  // Sequential shifter control states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/shifter_sll_seq_stage.sv
// One log-shifter stage: conditionally shift left by 2**stage, zero fill from the LSB.
module shifter_sll_seq_stage #(
  parameter int unsigned Width  = 32,
  parameter int unsigned StageW = 3
) (
  input  logic [Width-1:0]  i_data,
  input  logic [StageW-1:0] i_stage,
  input  logic              i_en,
  output logic [Width-1:0]  o_data
);

  logic [Width-1:0] w_shifted;

  // Shift distances past the word width simply yield zero.
  assign w_shifted = i_data << (Width'(1) << i_stage);

  // 2:1 select between shifted and pass-through operand.
  assign o_data = i_en ? w_shifted : i_data;

endmodule

// File: rtl/shifter_sll_seq.sv
// Multi-cycle logical-left shifter: one power-of-two stage per clock, start/busy/done handshake.
// Non-SLL function codes pass i_data_a straight through with a single-cycle latency.
module shifter_sll_seq
  import shifter_sll_seq_pkg::*;
#(
  parameter int unsigned Width   = AluWidth,
  parameter int unsigned ShamtW  = AluShamtW,
  parameter logic [5:0]  SllCode = FnSll
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [Width-1:0] i_data_a,
  input  logic [Width-1:0] i_data_b,
  input  logic [5:0]       i_signal,
  output logic             o_busy,
  output logic             o_done,
  output logic [Width-1:0] o_data_out
);

  localparam int unsigned StageW = (ShamtW > 1) ? $clog2(ShamtW) : 1;

  shift_state_e      r_state, w_state_d;
  logic [StageW-1:0] r_stage, w_stage_d;
  logic [ShamtW-1:0] r_amt, w_amt_d;
  logic [Width-1:0]  r_acc, w_acc_d;
  logic [Width-1:0]  r_data_out, w_data_out_d;

  logic             w_accept;
  logic             w_is_sll;
  logic             w_last;
  logic [Width-1:0] w_stage_out;

  // Only the low ShamtW bits of the amount operand matter.
  logic unused_data_b;
  assign unused_data_b = ^i_data_b[Width-1:ShamtW];

  // A request is taken whenever no shift is in flight (idle or the done cycle).
  assign w_accept = i_start && (r_state != StShift);
  assign w_is_sll = (i_signal == SllCode);
  assign w_last   = (r_stage == StageW'(ShamtW - 1));

  shifter_sll_seq_stage #(
    .Width  (Width),
    .StageW (StageW)
  ) u_stage (
    .i_data  (r_acc),
    .i_stage (r_stage),
    .i_en    (r_amt[r_stage]),
    .o_data  (w_stage_out)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (w_accept) begin
          w_state_d = w_is_sll ? StShift : StDone;
        end else begin
          w_state_d = StIdle;
        end
      end
      StShift: begin
        if (w_last) begin
          w_state_d = StDone;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    unique case (r_state)
      StShift: o_busy = 1'b1;
      StDone:  o_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: operand capture, per-stage accumulate, result publish on completion.
  always_comb begin
    w_stage_d    = r_stage;
    w_amt_d      = r_amt;
    w_acc_d      = r_acc;
    w_data_out_d = r_data_out;
    if (w_accept) begin
      if (w_is_sll) begin
        w_acc_d   = i_data_a;
        w_amt_d   = i_data_b[ShamtW-1:0];
        w_stage_d = '0;
      end else begin
        w_data_out_d = i_data_a;
      end
    end else if (r_state == StShift) begin
      w_acc_d = w_stage_out;
      if (w_last) begin
        // Result becomes visible only here, never as a partial accumulator value.
        w_data_out_d = w_stage_out;
        w_stage_d    = '0;
      end else begin
        w_stage_d = r_stage + StageW'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stage    <= '0;
      r_amt      <= '0;
      r_acc      <= '0;
      r_data_out <= '0;
    end else begin
      r_stage    <= w_stage_d;
      r_amt      <= w_amt_d;
      r_acc      <= w_acc_d;
      r_data_out <= w_data_out_d;
    end
  end

  assign o_data_out = r_data_out;

endmodule

// File: doc/shifter_sll_seq.md
Name: shifter_sll_seq

Overview:
- Multi-cycle logical-left shifter (SLL) for the EX stage. It is the left-shift counterpart of the existing combinational right shifter.
- It evaluates one log-shifter stage per clock, shifting by 1, 2, 4, 8, then 16 bits. This keeps the 32-bit mux tree off the EX critical path.
- It uses a start/busy/done handshake with the pipeline control. While busy is high, the hazard unit stalls the pipeline.
- For any non-SLL function code, it passes dataA through unchanged with 1-cycle latency.

Parameters:
- WIDTH, 32, data width. Must be a power of two.
- SHAMT_W, 5, shift-amount width (log2 WIDTH). This is also the number of stages.
- SLL, 6'b000000, function code that selects the left shift.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- rst_n  input  1  reset. Asynchronous, active-low.
- start  input  1  operation request. Sampled only when busy=0.
- dataA  input  WIDTH  operand to shift. Sampled with start.
- dataB  input  WIDTH  shift amount. Only bits [SHAMT_W-1:0] are used; upper bits are ignored.
- Signal  input  6  ALU function code. Sampled with start.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse; dataOut is valid in the same cycle.
- dataOut  output  WIDTH  result. Held stable until the next accepted start.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, stage counter=0, accumulator=0.
  - busy=0, done=0, dataOut=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 and Signal==SLL at edge E0: latch acc=dataA and amt=dataB[SHAMT_W-1:0]; set stage=0; go to SHIFT; busy=1.
  - start=1 and Signal!=SLL at E0: dataOut<=dataA; go to DONE; done=1 for the following cycle; busy stays 0.
- SHIFT:
  - At each edge, if amt[stage]=1 then acc<=acc<<(1<<stage), else acc is unchanged. Zeros fill from the LSB.
  - Then stage increments.
  - At the edge that applies stage SHAMT_W-1 (E5 for defaults): dataOut<=result, busy<=0, go to DONE, done=1.
- SLL latency: done rises 5 edges after the start-sampling edge, independent of the amount. A shift of 0 takes the same time.
- DONE:
  - Lasts exactly one cycle, with done=1.
  - start=1 in DONE is accepted with the same rules as in IDLE, allowing back-to-back operations.
  - Otherwise the block returns to IDLE.
- start while busy=1 is ignored, with no side effects. dataA, dataB and Signal may change freely while busy.
- dataOut changes only at completion (the DONE entry edge). It never shows partial accumulator values.
- Reset asserted mid-operation: abort immediately, no done pulse, all outputs return to reset values.
- Arithmetic: pure logical shift. No sign extension, bits shifted out of the MSB are discarded, and there is no carry or overflow output.

Decomposition:
- Shared package alu_pkg holds:
  - function-code constants (SLL=6'b000000, SRL=6'b000010);
  - a state enum {IDLE, SHIFT, DONE};
  - the WIDTH/SHAMT_W defaults, shared with the right shifter.
- One sub-module is natural: sll_stage. It is a combinational conditional shift by a variable power of two, built from MUX2_1-style selection, and is instantiated once and indexed by the stage counter.
- The FSM, counter and registers live in the top level.

Test Plan:
- dataA=0x00000001, dataB=31, Signal=SLL, start for 1 cycle → busy high for 5 cycles, then done pulse with dataOut=0x80000000.
- dataA=0xDEADBEEF, dataB=4, SLL → dataOut=0xEADBEEF0 at done, 5 edges after start.
- dataA=0xDEADBEEF, dataB=0x00000020 (bit 5 set, amount 0), SLL → dataOut=0xDEADBEEF, still 5-edge latency.
- Signal=6'b000010 (SRL), dataA=0x12345678 → done 1 edge after start, dataOut=0x12345678, busy never asserted.
- Second start with dataA=0xFFFFFFFF pulsed during busy, then start asserted in the done cycle with dataA=0x0000FFFF, dataB=16 → first result unaffected; second result 0xFFFF0000.
- rst_n driven low at stage 2 of a shift, then released → busy=0, done=0, dataOut=0, no done pulse; the next start completes normally.
